inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 128 ++++++++++++
 tb/tb_inst_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: program counter, req/ack fetch from instruction memory, and a
// single-entry instruction register handed to the decoder with a valid/ready handshake.
module inst_fetch #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [15:0]     imem_rdata_i,
    output logic [15:0]     inst_o,
    output logic [PC_W-1:0] inst_pc_o,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            halted_o
);

    typedef enum logic [2:0] {StStart, StFetch, StWait, StDrop, StHalt} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [15:0]     inst_q, inst_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;
    logic            halt_pend_q, halt_pend_d;

    logic            req;
    logic [PC_W-1:0] addr;
    logic            pending;
    logic            halt_eff;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        valid_d     = valid_q;
        halt_pend_d = halt_pend_q;
        req         = 1'b0;
        addr        = pc_q;

        unique case (state_q)
            StFetch:        req = ~valid_q | inst_ready_i;
            StWait, StDrop: begin
                req  = 1'b1;
                addr = addr_q;
            end
            default: ;
        endcase

        // A request still open after this cycle must be retired through StDrop.
        pending  = req & ~imem_ack_i;
        halt_eff = halt_i | halt_pend_q;

        if (state_q != StHalt) begin
            if (halt_eff) begin
                valid_d = 1'b0;
                if (pending) begin
                    state_d     = StDrop;
                    addr_d      = addr;
                    halt_pend_d = 1'b1;
                end else begin
                    state_d = StHalt;
                end
            end else if (redirect_i) begin
                pc_d    = redirect_pc_i;
                valid_d = 1'b0;
                if (pending) begin
                    state_d = StDrop;
                    addr_d  = addr;
                end else begin
                    state_d = StFetch;
                end
            end else if (state_q == StStart) begin
                state_d = StFetch;
            end else if (state_q == StDrop) begin
                if (imem_ack_i) state_d = StFetch;
            end else if (req && imem_ack_i) begin
                inst_d    = imem_rdata_i;
                inst_pc_d = addr;
                valid_d   = 1'b1;
                pc_d      = addr + PC_W'(1);
                state_d   = StFetch;
            end else begin
                if (state_q == StFetch && req) begin
                    addr_d  = pc_q;
                    state_d = StWait;
                end
                if (valid_q && inst_ready_i) valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StStart;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            inst_q      <= 16'h0000;
            inst_pc_q   <= '0;
            valid_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            valid_q     <= valid_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = addr;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign halted_o     = (state_q == StHalt);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural memory with programmable ack latency, directed scenarios
// and a randomized ready/redirect run checked against an instruction-stream model.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        req, ack, ready, redirect, halt, valid, halted;
    logic [15:0] addr, rdata, inst, inst_pc, rpc;
    logic        req2, valid2, halted2;
    logic [15:0] addr2, inst2, inst_pc2;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int cnt;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // Memory: ack after `lat` cycles of a held request (lat=0 acks in the request cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else        cnt <= (req && !ack) ? cnt + 1 : 0;
    end
    assign ack   = req && (cnt >= lat);
    assign rdata = mem_f(addr);

    inst_fetch #(.PC_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (valid),
        .inst_ready_i (ready),
        .redirect_i   (redirect),
        .redirect_pc_i(rpc),
        .halt_i       (halt),
        .halted_o     (halted)
    );

    inst_fetch #(.PC_W(16), .RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (req2),
        .imem_addr_o  (addr2),
        .imem_ack_i   (req2),
        .imem_rdata_i (mem_f(addr2)),
        .inst_o       (inst2),
        .inst_pc_o    (inst_pc2),
        .inst_valid_o (valid2),
        .inst_ready_i (1'b1),
        .redirect_i   (1'b0),
        .redirect_pc_i(16'h0000),
        .halt_i       (1'b0),
        .halted_o     (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input int l);
        rst_n = 1'b0; lat = l; ready = 1'b1; redirect = 1'b0; halt = 1'b0; rpc = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 40 && valid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_timeout: inst_valid=%b want 1", name, valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; lat = 0; ready = 1'b1; redirect = 1'b0; halt = 1'b0; rpc = 16'h0000;
        @(negedge clk);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req); end
        n_checks++; if (addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", addr); end
        n_checks++; if (inst !== 16'h0000) begin n_fail++; $display("FAIL rst_inst: got %h want 0000", inst); end
        n_checks++; if (inst_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0000", inst_pc); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
        n_checks++; if (addr2 !== 16'hFFFE) begin n_fail++; $display("FAIL rst_addr_wrap: got %h want fffe", addr2); end
    endtask

    task automatic test_stream;
        do_reset(0);
        @(negedge clk);
        n_checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0000) begin
            n_fail++; $display("FAIL stream_first_req: valid=%b req=%b addr=%h want 0 1 0000", valid, req, addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (valid !== 1'b1 || inst !== mem_f(16'(k)) || inst_pc !== 16'(k)) begin
                n_fail++; $display("FAIL stream_%0d: valid=%b inst=%h pc=%h want 1 %h %h", k, valid, inst,
                                   inst_pc, mem_f(16'(k)), 16'(k));
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp;
        do_reset(0);
        repeat (2) @(negedge clk);
        exp = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (valid2 !== 1'b1 || inst_pc2 !== exp || inst2 !== mem_f(exp)) begin
                n_fail++; $display("FAIL wrap_%0d: valid=%b pc=%h inst=%h want 1 %h %h", k, valid2, inst_pc2,
                                   inst2, exp, mem_f(exp));
            end
            exp = exp + 16'h0001;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        do_reset(2);
        wait_valid("bp");
        ready = 1'b0;
        #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop: got %b want 0", req); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (req !== 1'b0 || valid !== 1'b1 || inst !== 16'h1000 || inst_pc !== 16'h0000) begin
                n_fail++; $display("FAIL bp_hold_%0d: req=%b valid=%b inst=%h pc=%h want 0 1 1000 0000", k, req,
                                   valid, inst, inst_pc);
            end
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        n_checks++; if (req !== 1'b1 || addr !== 16'h0001) begin
            n_fail++; $display("FAIL bp_resume: req=%b addr=%h want 1 0001", req, addr);
        end
    endtask

    task automatic test_redirect_drop;
        bit found, got_ack;
        do_reset(3);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (req === 1'b1 && addr === 16'h0005) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rd_reach_addr5: not seen, want req at 0005"); end
        redirect = 1'b1; rpc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0; rpc = 16'h0000;
        got_ack = 0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (req !== 1'b1 || addr !== 16'h0005 || valid !== 1'b0) begin
                n_fail++; $display("FAIL rd_hold_%0d: req=%b addr=%h valid=%b want 1 0005 0", i, req, addr, valid);
            end
            if (ack === 1'b1) begin got_ack = 1; break; end
            @(negedge clk);
        end
        n_checks++; if (!got_ack) begin n_fail++; $display("FAIL rd_ack: no ack, want ack for 0005"); end
        @(negedge clk);
        n_checks++; if (req !== 1'b1 || addr !== 16'h0040 || valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_new_req: req=%b addr=%h valid=%b want 1 0040 0", req, addr, valid);
        end
        wait_valid("rd");
        n_checks++; if (inst_pc !== 16'h0040 || inst !== 16'h1040) begin
            n_fail++; $display("FAIL rd_target: pc=%h inst=%h want 0040 1040", inst_pc, inst);
        end
    endtask

    task automatic test_halt_redirect;
        do_reset(2);
        wait_valid("hr");
        halt = 1'b1; redirect = 1'b1; rpc = 16'h0040;
        @(negedge clk);
        halt = 1'b0; redirect = 1'b0;
        n_checks++; if (valid !== 1'b0 || halted !== 1'b0 || req !== 1'b1 || addr !== 16'h0001) begin
            n_fail++; $display("FAIL hr_drop: valid=%b halted=%b req=%b addr=%h want 0 0 1 0001", valid, halted,
                               req, addr);
        end
        for (int i = 0; i < 10 && req === 1'b1; i++) @(negedge clk);
        n_checks++; if (req !== 1'b0 || halted !== 1'b1) begin
            n_fail++; $display("FAIL hr_halted: req=%b halted=%b want 0 1", req, halted);
        end
        for (int k = 0; k < 6; k++) begin
            ready = 1'($urandom_range(0, 1)); redirect = 1'($urandom_range(0, 1));
            halt = 1'($urandom_range(0, 1)); rpc = 16'($urandom_range(0, 255));
            @(negedge clk);
            n_checks++; if (req !== 1'b0 || halted !== 1'b1 || valid !== 1'b0) begin
                n_fail++; $display("FAIL hr_stay_%0d: req=%b halted=%b valid=%b want 0 1 0", k, req, halted, valid);
            end
        end
        redirect = 1'b0; halt = 1'b0; ready = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        do_reset(3);
        wait_valid("rw");
        repeat (2) @(negedge clk);
        n_checks++; if (req !== 1'b1 || addr !== 16'h0001 || valid !== 1'b0) begin
            n_fail++; $display("FAIL rw_in_wait: req=%b addr=%h valid=%b want 1 0001 0", req, addr, valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (req !== 1'b0 || addr !== 16'h0000 || inst !== 16'h0000 || inst_pc !== 16'h0000 ||
                        valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL rw_async: req=%b addr=%h inst=%h pc=%h valid=%b halted=%b want all 0",
                               req, addr, inst, inst_pc, valid, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req !== 1'b1 || addr !== 16'h0000) begin
            n_fail++; $display("FAIL rw_restart: req=%b addr=%h want 1 0000", req, addr);
        end
    endtask

    // Model: the decoder sees consecutive words from the last redirect target (or RESET_PC),
    // each equal to mem[inst_pc], and a stalled word stays put until taken.
    task automatic test_random;
        logic [15:0] exp_pc;
        bit          hold_exp;
        int          n_cons;
        for (int l = 0; l < 4; l++) begin
            do_reset(l);
            exp_pc = 16'h0000; hold_exp = 0; n_cons = 0;
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                if (hold_exp) begin
                    n_checks++; if (valid !== 1'b1) begin
                        n_fail++; $display("FAIL rand_hold_l%0d_c%0d: valid=%b want 1", l, c, valid);
                    end
                end
                if (valid === 1'b1) begin
                    n_checks++; if (inst_pc !== exp_pc || inst !== mem_f(exp_pc)) begin
                        n_fail++; $display("FAIL rand_ir_l%0d_c%0d: pc=%h inst=%h want %h %h", l, c, inst_pc,
                                           inst, exp_pc, mem_f(exp_pc));
                    end
                end
                ready    = ($urandom_range(0, 3) != 0);
                redirect = ($urandom_range(0, 15) == 0);
                rpc      = 16'($urandom_range(0, 255));
                if (redirect) begin
                    exp_pc = rpc;
                end else if (valid === 1'b1 && ready) begin
                    exp_pc = exp_pc + 16'h0001;
                    n_cons++;
                end
                hold_exp = (valid === 1'b1) && !ready && !redirect;
            end
            redirect = 1'b0;
            n_checks++; if (n_cons < 15) begin
                n_fail++; $display("FAIL rand_progress_l%0d: consumed %0d want >= 15", l, n_cons);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect_drop();
        test_halt_redirect();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
